// File: rtl/pq_enq_feeder.sv
// pq_enq_feeder: small circular input buffer that feeds a priority queue.
// Words are issued one at a time through an IDLE/ISSUE/GAP sequence, so
// pq_enq strobes are at least 3 cycles apart and never while the queue is
// full or busy. Optional enqueue statistics: define PQ_ENQ_FEEDER_STATS_EN.

package pq_pkg;
  typedef struct packed {
    logic [7:0] key;
    logic [7:0] value;
  } kv_t;
endpackage

module pq_enq_feeder #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  pq_pkg::kv_t            in_kv,
  input  logic                   in_valid,
  output logic                   in_ready,
  output pq_pkg::kv_t            pq_kvi,
  output logic                   pq_enq,
  input  logic                   pq_full,
  input  logic                   pq_busy,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            enq_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          pq_enq_reg, pq_enq_next;
  pq_pkg::kv_t   pq_kvi_reg;
  logic          push, pop;

  pq_pkg::kv_t   mem [DEPTH];

  // Ready depends only on the registered occupancy; a same-cycle pop does
  // not open a slot. Inputs are ignored while reset is asserted.
  assign in_ready = (count_reg != FULL_CNT);
  assign push     = rst && in_valid && in_ready;

  // State register and registered enqueue strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      pq_enq_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pq_enq_reg <= pq_enq_next;
    end
  end

  // Next-state: leave IDLE only when a word is buffered and the queue is
  // free; ISSUE and GAP always advance.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if ((count_reg != '0) && !pq_full && !pq_busy) state_next = ISSUE;
      ISSUE:   state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: pop the head on the IDLE->ISSUE edge, strobe while in ISSUE.
  always_comb begin
    pop         = 1'b0;
    pq_enq_next = 1'b0;
    if ((state_reg == IDLE) && (state_next == ISSUE)) begin
      pop         = 1'b1;
      pq_enq_next = 1'b1;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^PW.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Buffer storage write port (no reset so it can map to RAM).
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= in_kv;
  end

  // Registered read of the head word; holds the last issued word otherwise.
  always_ff @(posedge clk) begin
    if (!rst) pq_kvi_reg <= '0;
    else if (pop) pq_kvi_reg <= mem[rd_ptr_reg];
  end

  assign pq_kvi = pq_kvi_reg;
  assign pq_enq = pq_enq_reg;
  assign count  = count_reg;

`ifdef PQ_ENQ_FEEDER_STATS_EN
  logic [15:0] enq_count_reg;

  // Count issued strobes; wraps at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst) enq_count_reg <= '0;
    else if (pq_enq_reg) enq_count_reg <= enq_count_reg + 16'd1;
  end

  assign enq_count = enq_count_reg;
`else
  assign enq_count = '0;
`endif

endmodule

// File: tb/tb_pq_enq_feeder.sv
// Testbench for pq_enq_feeder: a vector table for the basic issue and
// back-pressure flow, then hand-written sequences for wrap, stall, reset
// during issue and the optional statistics counter.

module tb_pq_enq_feeder;

  logic        clk = 1'b0;
  logic        rst;
  pq_pkg::kv_t in_kv;
  logic        in_valid;
  logic        in_ready;
  pq_pkg::kv_t pq_kvi;
  logic        pq_enq;
  logic        pq_full;
  logic        pq_busy;
  logic [2:0]  count;
  logic [15:0] enq_count;

  pq_enq_feeder #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_kv(in_kv), .in_valid(in_valid),
    .in_ready(in_ready), .pq_kvi(pq_kvi), .pq_enq(pq_enq),
    .pq_full(pq_full), .pq_busy(pq_busy), .count(count),
    .enq_count(enq_count)
  );

  always #5 clk = ~clk;

`ifdef PQ_ENQ_FEEDER_STATS_EN
  localparam int EXP_STATS = 7;
`else
  localparam int EXP_STATS = 0;
`endif

  typedef struct {
    logic       r;
    logic       v;
    logic [7:0] kv;
    logic       f;
    logic       b;
    logic       e_rdy;
    logic       e_enq;
    logic [7:0] e_kvi;
    int         e_cnt;
  } vec_t;

  vec_t        tbl [20];
  int          nvec = 0;
  int          nerr = 0;
  int          cyc = 0;
  int          last_strobe = -100;
  int          nstrobe = 0;
  logic [15:0] expq [$];

  function automatic vec_t mk(input logic r, input logic v, input logic [7:0] kv,
                              input logic f, input logic b, input logic e_rdy,
                              input logic e_enq, input logic [7:0] e_kvi, input int e_cnt);
    vec_t t;
    t.r = r; t.v = v; t.kv = kv; t.f = f; t.b = b;
    t.e_rdy = e_rdy; t.e_enq = e_enq; t.e_kvi = e_kvi; t.e_cnt = e_cnt;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One cycle with the strobe scoreboard: order, no stale words, spacing >= 3.
  task automatic step();
    logic [15:0] exp;
    tick();
    if (pq_enq) begin
      nvec++;
      nstrobe++;
      if (expq.size() == 0) begin
        nerr++;
        $display("FAIL strobe_unexpected: got kvi=%h, required no strobe", 16'(pq_kvi));
      end else begin
        exp = expq.pop_front();
        if (16'(pq_kvi) !== exp || (cyc - last_strobe) < 3) begin
          nerr++;
          $display("FAIL strobe_order: got kvi=%h gap=%0d, required kvi=%h gap>=3",
                   16'(pq_kvi), cyc - last_strobe, exp);
        end else begin
          $display("strobe cyc=%0d kvi=%h", cyc, 16'(pq_kvi));
        end
      end
      last_strobe = cyc;
    end
  endtask

  task automatic push_words(input int n, input logic [7:0] base);
    int   i = 0;
    int   guard = 0;
    logic acc;
    while (i < n && guard < 200) begin
      in_valid = 1'b1;
      in_kv    = {8'h00, 8'(base + i)};
      acc      = in_ready;
      if (acc) expq.push_back({8'h00, 8'(base + i)});
      step();
      if (acc) begin
        $display("push cyc=%0d kv=%h", cyc, 8'(base + i));
        i++;
      end
      guard++;
    end
    in_valid = 1'b0;
    nvec++;
    if (i != n) begin
      nerr++;
      $display("FAIL push_timeout: accepted %0d words, required %0d", i, n);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (!(expq.size() == 0 && count == 0) && guard < 100) begin
      step();
      guard++;
    end
    repeat (3) step();
    nvec++;
    if (expq.size() != 0 || count != 0) begin
      nerr++;
      $display("FAIL drain: pending=%0d count=%0d, required 0 and 0", expq.size(), count);
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    nvec++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end else begin
      $display("check %s = %0d", name, act);
    end
  endtask

  initial begin
    int s0;
    rst = 1'b0; in_valid = 1'b0; in_kv = '0; pq_full = 1'b0; pq_busy = 1'b0;

    //            r  v  kv     f  b  rdy enq kvi    cnt
    tbl[0]  = mk(0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0);
    tbl[1]  = mk(1, 1, 8'h11, 0, 0, 1, 0, 8'h00, 1);
    tbl[2]  = mk(1, 1, 8'h22, 0, 0, 1, 1, 8'h11, 1);
    tbl[3]  = mk(1, 1, 8'h33, 0, 0, 1, 0, 8'h11, 2);
    tbl[4]  = mk(1, 0, 8'h00, 0, 0, 1, 0, 8'h11, 2);
    tbl[5]  = mk(1, 0, 8'h00, 0, 0, 1, 1, 8'h22, 1);
    tbl[6]  = mk(1, 0, 8'h00, 0, 0, 1, 0, 8'h22, 1);
    tbl[7]  = mk(1, 0, 8'h00, 0, 0, 1, 0, 8'h22, 1);
    tbl[8]  = mk(1, 0, 8'h00, 0, 0, 1, 1, 8'h33, 0);
    tbl[9]  = mk(1, 0, 8'h00, 0, 0, 1, 0, 8'h33, 0);
    tbl[10] = mk(1, 0, 8'h00, 0, 0, 1, 0, 8'h33, 0);
    tbl[11] = mk(1, 1, 8'hA1, 0, 1, 1, 0, 8'h33, 1);
    tbl[12] = mk(1, 1, 8'hA2, 0, 1, 1, 0, 8'h33, 2);
    tbl[13] = mk(1, 1, 8'hA3, 0, 1, 1, 0, 8'h33, 3);
    tbl[14] = mk(1, 1, 8'hA4, 0, 1, 0, 0, 8'h33, 4);
    tbl[15] = mk(1, 1, 8'hA5, 0, 1, 0, 0, 8'h33, 4);
    tbl[16] = mk(1, 1, 8'hA5, 0, 0, 1, 1, 8'hA1, 3);
    tbl[17] = mk(1, 1, 8'hA5, 0, 0, 0, 0, 8'hA1, 4);
    tbl[18] = mk(1, 0, 8'h00, 0, 0, 0, 0, 8'hA1, 4);
    tbl[19] = mk(1, 0, 8'h00, 0, 0, 1, 1, 8'hA2, 3);

    for (int i = 0; i < 20; i++) begin
      rst = tbl[i].r; in_valid = tbl[i].v; in_kv = {8'h00, tbl[i].kv};
      pq_full = tbl[i].f; pq_busy = tbl[i].b;
      tick();
      if (pq_enq) last_strobe = cyc;
      nvec++;
      if (in_ready !== tbl[i].e_rdy || pq_enq !== tbl[i].e_enq ||
          16'(pq_kvi) !== {8'h00, tbl[i].e_kvi} || int'(count) != tbl[i].e_cnt) begin
        nerr++;
        $display("FAIL vec%0d: got rdy=%b enq=%b kvi=%h cnt=%0d, required rdy=%b enq=%b kvi=%h cnt=%0d",
                 i, in_ready, pq_enq, 16'(pq_kvi), count,
                 tbl[i].e_rdy, tbl[i].e_enq, {8'h00, tbl[i].e_kvi}, tbl[i].e_cnt);
      end else begin
        $display("vec%0d rdy=%b enq=%b kvi=%h cnt=%0d", i, in_ready, pq_enq, 16'(pq_kvi), count);
      end
    end
    in_valid = 1'b0;

    // Remaining back-pressure words, then 20 words at full input rate.
    expq.push_back(16'h00A3); expq.push_back(16'h00A4); expq.push_back(16'h00A5);
    drain();
    s0 = nstrobe;
    push_words(20, 8'h40);
    drain();
    check("wrap_strobes", nstrobe - s0, 20);

    // Full held for 10 cycles with two words buffered.
    pq_full = 1'b1;
    push_words(2, 8'hC0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("full_no_enq", int'(pq_enq), 0);
    end
    check("full_count", int'(count), 2);
    pq_full = 1'b0;
    step();
    check("full_resume", int'(pq_enq), 1);
    drain();

    // Reset while a strobe is out, with three words still buffered.
    pq_busy = 1'b1;
    push_words(4, 8'hD0);
    pq_busy = 1'b0;
    step();
    check("rst_pre_enq", int'(pq_enq), 1);
    check("rst_pre_count", int'(count), 3);
    rst = 1'b0;
    tick();
    check("rst_enq", int'(pq_enq), 0);
    check("rst_count", int'(count), 0);
    rst = 1'b1;
    expq.delete();
    repeat (10) step();
    check("rst_post_count", int'(count), 0);
    check("rst_post_ready", int'(in_ready), 1);

    // Statistics counter after exactly seven enqueues from reset.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("stats_reset", int'(enq_count), 0);
    s0 = nstrobe;
    push_words(7, 8'h60);
    drain();
    check("stats_strobes", nstrobe - s0, 7);
    check("stats_enq_count", int'(enq_count), EXP_STATS);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
